// File: rtl/mac_sequencer_if.sv
// Instruction-queue handshake plus unified-buffer, weight-FIFO and MAC-array strobes
// of the MAC sequencer; slave = the sequencer, master = the surrounding system.
interface mac_sequencer_if #(
  parameter int ADDR_W    = 12,
  parameter int DIM_W     = 8,
  parameter int WT_ADDR_W = 16
);
  logic                 instr_valid_i;
  logic [2:0]           mac_op_i;
  logic [DIM_W-1:0]     v_dim_i;
  logic [DIM_W-1:0]     u_dim_i;
  logic [DIM_W-1:0]     iter_dim_i;
  logic [ADDR_W-1:0]    ub_rd_start_i;
  logic [ADDR_W-1:0]    ub_wr_start_i;

  logic                 instr_read_o;
  logic                 wt_load_o;
  logic [WT_ADDR_W-1:0] wt_addr_o;
  logic                 ub_rd_en_o;
  logic [ADDR_W-1:0]    ub_rd_addr_o;
  logic                 mac_en_o;
  logic                 ub_wr_en_o;
  logic [ADDR_W-1:0]    ub_wr_addr_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  instr_valid_i, mac_op_i, v_dim_i, u_dim_i, iter_dim_i,
           ub_rd_start_i, ub_wr_start_i,
    output instr_read_o, wt_load_o, wt_addr_o, ub_rd_en_o, ub_rd_addr_o,
           mac_en_o, ub_wr_en_o, ub_wr_addr_o, busy_o, done_o
  );

  modport master (
    output instr_valid_i, mac_op_i, v_dim_i, u_dim_i, iter_dim_i,
           ub_rd_start_i, ub_wr_start_i,
    input  instr_read_o, wt_load_o, wt_addr_o, ub_rd_en_o, ub_rd_addr_o,
           mac_en_o, ub_wr_en_o, ub_wr_addr_o, busy_o, done_o
  );
endinterface

// File: rtl/mac_sequencer.sv
// Sequences one matrix-multiply job on the systolic MAC array: weight loads, activation
// streaming and delayed result write-back.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for an instruction; pops and latches it
//   S_LOAD_W | loading U weight rows for the current iteration
//   S_STREAM | streaming V activation rows into the array
//   S_DRAIN  | waiting for the last result to leave the write delay line
//   S_DONE   | one-cycle retire pulse
module mac_sequencer #(
  parameter int ADDR_W    = 12,
  parameter int DIM_W     = 8,
  parameter int WT_ADDR_W = 16,
  parameter int PIPE_LAT  = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mac_sequencer_if.slave bus
);
  localparam logic [2:0] OP_MAC = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [DIM_W-1:0]     cnt_q, cnt_d;
  logic [DIM_W-1:0]     iter_left_q, iter_left_d;
  logic [DIM_W-1:0]     u_q, u_d;
  logic [DIM_W-1:0]     v_q, v_d;
  logic [WT_ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [PIPE_LAT-1:0]  pipe_q, pipe_d;
  logic [PIPE_LAT-1:0]  pipe_older;

  logic instr_read, is_mac, dims_zero;
  logic wt_load, rd_en, wr_en, busy, done;

  assign is_mac    = (bus.mac_op_i == OP_MAC);
  assign dims_zero = (bus.v_dim_i == '0) || (bus.u_dim_i == '0) || (bus.iter_dim_i == '0);
  // Everything in the delay line except the entry being written this cycle.
  assign pipe_older = pipe_q << 1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (instr_read && is_mac) state_d = dims_zero ? S_DONE : S_LOAD_W;
      S_LOAD_W: if (cnt_q == '0) state_d = S_STREAM;
      S_STREAM: if (cnt_q == '0) state_d = (iter_left_q == '0) ? S_DRAIN : S_LOAD_W;
      S_DRAIN:  if (pipe_older == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // The pop strobe is gated by reset so that no output is high while reset is held.
  always_comb begin
    instr_read = (state_q == S_IDLE) && bus.instr_valid_i && rst_i;
    wt_load    = (state_q == S_LOAD_W);
    rd_en      = (state_q == S_STREAM);
    wr_en      = pipe_q[PIPE_LAT-1];
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);
  end

  // Weight rows are loaded in strictly increasing order across iterations, so a
  // running counter yields iter_cnt*U + k without a multiplier.
  always_comb begin
    cnt_d       = cnt_q;
    iter_left_d = iter_left_q;
    u_d         = u_q;
    v_d         = v_q;
    wt_addr_d   = wt_addr_q;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    pipe_d      = (pipe_q << 1) | PIPE_LAT'(rd_en);
    if (wr_en) wr_addr_d = wr_addr_q + ADDR_W'(1);
    unique case (state_q)
      S_IDLE: begin
        if (instr_read) begin
          u_d         = bus.u_dim_i;
          v_d         = bus.v_dim_i;
          iter_left_d = bus.iter_dim_i - DIM_W'(1);
          cnt_d       = bus.u_dim_i - DIM_W'(1);
          wt_addr_d   = '0;
          rd_addr_d   = bus.ub_rd_start_i;
          wr_addr_d   = bus.ub_wr_start_i;
        end
      end
      S_LOAD_W: begin
        wt_addr_d = wt_addr_q + WT_ADDR_W'(1);
        cnt_d     = (cnt_q == '0) ? v_q - DIM_W'(1) : cnt_q - DIM_W'(1);
      end
      S_STREAM: begin
        rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (cnt_q == '0) begin
          cnt_d       = u_q - DIM_W'(1);
          iter_left_d = iter_left_q - DIM_W'(1);
        end else begin
          cnt_d = cnt_q - DIM_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      iter_left_q <= '0;
      u_q         <= '0;
      v_q         <= '0;
      wt_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      pipe_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      iter_left_q <= iter_left_d;
      u_q         <= u_d;
      v_q         <= v_d;
      wt_addr_q   <= wt_addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      pipe_q      <= pipe_d;
    end
  end

  assign bus.instr_read_o = instr_read;
  assign bus.wt_load_o    = wt_load;
  assign bus.wt_addr_o    = wt_addr_q;
  assign bus.ub_rd_en_o   = rd_en;
  assign bus.ub_rd_addr_o = rd_addr_q;
  assign bus.mac_en_o     = rd_en;
  assign bus.ub_wr_en_o   = wr_en;
  assign bus.ub_wr_addr_o = wr_addr_q;
  assign bus.busy_o       = busy;
  assign bus.done_o       = done;
endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: directed and random job sequences compared cycle by cycle
// against a timeline built from the job-level timing rules, plus a mid-job reset.
module tb_mac_sequencer;
  localparam int ADDR_W    = 12;
  localparam int DIM_W     = 8;
  localparam int WT_ADDR_W = 16;
  localparam int PIPE_LAT  = 32;
  localparam int MAXT      = 1024;

  typedef struct {
    logic [2:0]  op;
    int          v;
    int          u;
    int          it;
    logic [11:0] rd;
    logic [11:0] wr;
  } job_t;

  logic clk;
  logic rst_i;
  int   n_checks = 0;
  int   n_errors = 0;

  job_t        jobs[$];
  int          jt0[16];
  logic        e_ir[MAXT], e_ld[MAXT], e_rd[MAXT], e_wr[MAXT], e_busy[MAXT], e_done[MAXT];
  logic [15:0] e_wa[MAXT];
  logic [11:0] e_ra[MAXT], e_wra[MAXT];

  mac_sequencer_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .WT_ADDR_W(WT_ADDR_W)) bus ();

  mac_sequencer #(
    .ADDR_W(ADDR_W), .DIM_W(DIM_W), .WT_ADDR_W(WT_ADDR_W), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Layout: ir[46] ld[45] wa[44:29] rd[28] ra[27:16] mac_en[15] wr[14] wra[13:2] busy[1] done[0]
  function automatic logic [63:0] pack_out(input logic ir, input logic ld, input logic [15:0] wa,
                                           input logic rd, input logic [11:0] ra, input logic me,
                                           input logic wr, input logic [11:0] wra,
                                           input logic busy, input logic done);
    return {17'd0, ir, ld, wa, rd, ra, me, wr, wra, busy, done};
  endfunction

  function automatic logic [63:0] sample_raw();
    return pack_out(bus.instr_read_o, bus.wt_load_o, bus.wt_addr_o, bus.ub_rd_en_o,
                    bus.ub_rd_addr_o, bus.mac_en_o, bus.ub_wr_en_o, bus.ub_wr_addr_o,
                    bus.busy_o, bus.done_o);
  endfunction

  // Addresses only matter in cycles where their strobe is expected.
  function automatic logic [63:0] mask_addr(input logic [63:0] v, input logic [63:0] e);
    logic [63:0] m;
    m = v;
    if (!e[45]) m[44:29] = '0;
    if (!e[28]) m[27:16] = '0;
    if (!e[14]) m[13:2]  = '0;
    return m;
  endfunction

  task automatic build_model(output int total);
    int t0;
    t0 = 0;
    for (int t = 0; t < MAXT; t++) begin
      e_ir[t] = 0; e_ld[t] = 0; e_rd[t] = 0; e_wr[t] = 0; e_busy[t] = 0; e_done[t] = 0;
      e_wa[t] = '0; e_ra[t] = '0; e_wra[t] = '0;
    end
    for (int j = 0; j < jobs.size(); j++) begin
      jt0[j] = t0;
      e_ir[t0] = 1;
      if (jobs[j].op != 3'b010) begin
        t0 = t0 + 1;
      end else if (jobs[j].v == 0 || jobs[j].u == 0 || jobs[j].it == 0) begin
        e_done[t0+1] = 1;
        e_busy[t0+1] = 1;
        t0 = t0 + 2;
      end else begin
        int n;
        int per;
        int d;
        n   = 0;
        per = jobs[j].u + jobs[j].v;
        for (int it = 0; it < jobs[j].it; it++) begin
          for (int k = 0; k < jobs[j].u; k++) begin
            int t;
            t = t0 + 1 + it * per + k;
            e_ld[t] = 1;
            e_wa[t] = 16'(it * jobs[j].u + k);
          end
          for (int r = 0; r < jobs[j].v; r++) begin
            int t;
            t = t0 + 1 + it * per + jobs[j].u + r;
            e_rd[t] = 1;
            e_ra[t] = jobs[j].rd + 12'(n);
            e_wr[t+PIPE_LAT]  = 1;
            e_wra[t+PIPE_LAT] = jobs[j].wr + 12'(n);
            n++;
          end
        end
        d = t0 + jobs[j].it * per + PIPE_LAT + 1;
        e_done[d] = 1;
        for (int b = t0 + 1; b <= d; b++) e_busy[b] = 1;
        t0 = d + 1;
      end
    end
    total = t0 + 4;
  endtask

  task automatic run_seq(input string name);
    int total;
    int ptr;
    logic [63:0] e;
    build_model(total);
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      ptr = -1;
      for (int j = 0; j < jobs.size(); j++)
        if (ptr < 0 && jt0[j] >= t) ptr = j;
      if (ptr >= 0) begin
        bus.instr_valid_i = 1'b1;
        bus.mac_op_i      = jobs[ptr].op;
        bus.v_dim_i       = 8'(jobs[ptr].v);
        bus.u_dim_i       = 8'(jobs[ptr].u);
        bus.iter_dim_i    = 8'(jobs[ptr].it);
        bus.ub_rd_start_i = jobs[ptr].rd;
        bus.ub_wr_start_i = jobs[ptr].wr;
      end else begin
        bus.instr_valid_i = 1'b0;
      end
      #1;
      e = pack_out(e_ir[t], e_ld[t], e_wa[t], e_rd[t], e_ra[t], e_rd[t],
                   e_wr[t], e_wra[t], e_busy[t], e_done[t]);
      check_val($sformatf("%s t%0d", name, t), mask_addr(sample_raw(), e), e);
    end
    jobs.delete();
  endtask

  function automatic job_t rand_job();
    job_t j;
    j.op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
    j.v  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
    j.u  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 5));
    j.it = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 3));
    j.rd = 12'($urandom);
    j.wr = 12'($urandom);
    return j;
  endfunction

  initial begin
    int wr_seen;
    int busy_seen;
    rst_i             = 1'b0;
    bus.instr_valid_i = 1'b1;
    bus.mac_op_i      = 3'b010;
    bus.v_dim_i       = 8'd1;
    bus.u_dim_i       = 8'd1;
    bus.iter_dim_i    = 8'd1;
    bus.ub_rd_start_i = 12'h123;
    bus.ub_wr_start_i = 12'h456;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_state", sample_raw(), 64'd0);
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    rst_i             = 1'b1;
    repeat (2) @(negedge clk);

    jobs.push_back('{3'b010, 4, 2, 1, 12'h010, 12'h200});
    run_seq("single");
    jobs.push_back('{3'b010, 3, 2, 2, 12'h040, 12'h300});
    run_seq("multi");
    jobs.push_back('{3'b010, 0, 3, 2, 12'h050, 12'h350});
    run_seq("zero_dim");
    jobs.push_back('{3'b000, 2, 2, 1, 12'h060, 12'h360});
    run_seq("non_mac");
    jobs.push_back('{3'b010, 4, 1, 1, 12'hFFE, 12'hFFF});
    run_seq("wrap");
    jobs.push_back('{3'b010, 2, 1, 1, 12'h070, 12'h400});
    jobs.push_back('{3'b010, 3, 2, 2, 12'h080, 12'h500});
    run_seq("b2b");

    for (int s = 0; s < 25; s++) begin
      int nj;
      nj = int'($urandom_range(1, 3));
      for (int j = 0; j < nj; j++) jobs.push_back(rand_job());
      run_seq($sformatf("rand%0d", s));
    end

    // Reset asserted in the second STREAM cycle of a V=4, U=2 job.
    @(negedge clk);
    bus.instr_valid_i = 1'b1;
    bus.mac_op_i      = 3'b010;
    bus.v_dim_i       = 8'd4;
    bus.u_dim_i       = 8'd2;
    bus.iter_dim_i    = 8'd1;
    bus.ub_rd_start_i = 12'h0A0;
    bus.ub_wr_start_i = 12'h0B0;
    @(negedge clk);
    bus.instr_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_pre_rd", {63'd0, bus.ub_rd_en_o}, 64'd1);
    rst_i = 1'b0;
    #1;
    check_val("rst_mid", sample_raw(), 64'd0);
    repeat (3) @(negedge clk);
    rst_i     = 1'b1;
    wr_seen   = 0;
    busy_seen = 0;
    for (int c = 0; c < 2 * PIPE_LAT; c++) begin
      @(negedge clk);
      #1;
      if (bus.ub_wr_en_o) wr_seen++;
      if (bus.busy_o) busy_seen++;
    end
    check_val("rst_no_wr", 64'(wr_seen), 64'd0);
    check_val("rst_idle", 64'(busy_seen), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
